serial_subtractor8: RTL and testbench
=====================================

Name: serial_subtractor8

Overview:
- Bit-serial unsigned subtractor with borrow. It is the inverse-direction companion to the team's combinational 8-bit ripple adder.
- Computes y = a - b - borrow_in one bit per clock, LSB first, through a single full-subtractor cell.
- A start/busy/done handshake brackets each operation.
- Used where area matters more than latency, and as a cross-check against the adder: adder(y, b, borrow_in) must reproduce a.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when busy = 0
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
borrow_in  input  1  borrow into bit 0, captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when y/borrow_out are updated
y  output  WIDTH  difference, (a - b - borrow_in) mod 2^WIDTH
borrow_out  output  1  1 iff a < b + borrow_in (unsigned)

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - busy = 0, done = 0, y = 0, borrow_out = 0.
  - Bit counter = 0, internal shift registers = 0, FSM = IDLE.
  - Reset asserted mid-operation aborts it; no done pulse is issued.
- FSM states:
  - IDLE: busy = 0. start = 1 at edge k -> latch a, b, borrow_in into internal registers; counter = 0; go to RUN; busy = 1 after edge k.
  - RUN: each edge processes bit i = counter.
    - d_i = a_i ^ b_i ^ br
    - br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d_i shifts into the result shift register MSB-ward; counter increments.
  - At edge k+WIDTH (last bit):
    - y <= full assembled difference; borrow_out <= final br.
    - done = 1 for exactly one cycle; busy = 0; return to IDLE.
- Latency: exactly WIDTH cycles from the start-accepting edge to done high. Throughput: one operation per WIDTH cycles.
- start while busy = 1 is ignored. Operands are not re-sampled; the in-flight result is unaffected.
- start high in the same cycle done is high (busy = 0) is accepted. done drops and busy rises after that edge.
- y and borrow_out do not change during RUN. They hold the previous result until the next completion and are never cleared by start.
- a, b, borrow_in may change freely after the accepting edge.
- Width rule: all arithmetic is modulo 2^WIDTH; borrow_out is the only overflow indication.
- start held high continuously: back-to-back operations, one every WIDTH+1 edges. The extra edge is the IDLE acceptance.

Test Plan:
- Reset, then a=5, b=5, borrow_in=0, start pulse -> done after exactly 8 cycles; y=0, borrow_out=0; busy high during the 8 cycles.
- a=13, b=5, borrow_in=0 -> y=8, borrow_out=0. Then a=8, b=5, borrow_in=1 -> y=2, borrow_out=0.
- Wrap-around:
  - a=3, b=5, borrow_in=0 -> y=254, borrow_out=1.
  - a=0, b=255, borrow_in=1 -> y=0, borrow_out=1.
  - a=255, b=0, borrow_in=0 -> y=255, borrow_out=0.
- Start a=20, b=7; at cycle 3 pulse start with a=1, b=2 and change the inputs -> single done pulse; y=13, borrow_out=0; second request ignored.
- Complete a=9, b=4 (y=5). Start a=100, b=1; drop rst_n at cycle 4 -> busy/done/y/borrow_out read 0 immediately (before the next edge); no done pulse. After release, a fresh a=100, b=1 -> y=99.
- start held high, operands 50-20 then 20-50 -> done pulses 9 edges apart; y=30, borrow_out=0, then y=226, borrow_out=1. Each result checked against a golden (a - b - borrow_in) & 8'hFF.

Source files
------------

// File: rtl/serial_subtractor8.sv
// Bit-serial unsigned subtractor: y = a - b - borrow_in, one bit per clock, LSB first.
// A single full-subtractor cell walks the operands; start/busy/done bracket each operation.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start; y/borrow_out hold the last result
//   S_RUN  | one operand bit per edge; the last bit publishes y and pulses done
module serial_subtractor8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;

  logic a_i;
  logic b_i;
  logic d_i;
  logic br_next;

  always_comb begin
    a_i     = a_sh[0];
    b_i     = b_sh[0];
    d_i     = a_i ^ b_i ^ br;
    br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  end

  assign busy = (state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      res        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      done       <= 1'b0;
      y          <= '0;
      borrow_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= borrow_in;
            res   <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // Operands shift down so the active bit is always at index 0.
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          br   <= br_next;
          res  <= {d_i, res[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            y          <= {d_i, res[WIDTH-1:1]};
            borrow_out <= br_next;
            done       <= 1'b1;
            cnt        <= '0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor8.sv
// Directed self-checking bench for serial_subtractor8 (WIDTH = 8).
// Inputs change at #1 after a rising edge or on the falling edge; outputs are sampled at #1 after the edge.
module tb_serial_subtractor8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       borrow_in;
  logic       busy;
  logic       done;
  logic [7:0] y;
  logic       borrow_out;

  int n_cmp;
  int n_bad;
  int edge_cnt;

  serial_subtractor8 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .y          (y),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  // Present operands with start for one accepting edge, then drop start.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic bin);
    @(negedge clk);
    a = av; b = bv; borrow_in = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen (sampled #1 after each edge); gives up after 40.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    #2;
    n_cmp++;
    if ({busy, done, y, borrow_out} !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b y=%0d bo=%b, want all 0", busy, done, y, borrow_out);
    end
    #20;
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_equal_latency;
    int cyc;
    int busy_low;
    start_op(8'd5, 8'd5, 1'b0);
    busy_low = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) busy_low++;
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++;
    if (cyc != 8) begin
      n_bad++;
      $display("FAIL latency_5m5: got %0d cycles, want 8", cyc);
    end
    n_cmp++;
    if (busy_low != 0) begin
      n_bad++;
      $display("FAIL busy_during_run: busy low in %0d cycles, want 0", busy_low);
    end
    n_cmp++;
    if (y !== 8'd0 || borrow_out !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL result_5m5: got y=%0d bo=%b busy=%b, want y=0 bo=0 busy=0", y, borrow_out, busy);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_one_cycle: got done=%b, want 0", done);
    end
  endtask

  task automatic test_basic;
    int cyc;
    start_op(8'd13, 8'd5, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc != 8 || y !== 8'd8 || borrow_out !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_13m5: got cyc=%0d y=%0d bo=%b, want cyc=8 y=8 bo=0", cyc, y, borrow_out);
    end
    start_op(8'd8, 8'd5, 1'b1);
    // Previous result must hold while the new operation runs.
    @(posedge clk); #1;
    n_cmp++;
    if (y !== 8'd8 || borrow_out !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_during_run: got y=%0d bo=%b, want y=8 bo=0", y, borrow_out);
    end
    wait_done(cyc);
    n_cmp++;
    if (cyc != 7 || y !== 8'd2 || borrow_out !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_8m5m1: got cyc=%0d y=%0d bo=%b, want cyc=7 y=2 bo=0", cyc, y, borrow_out);
    end
  endtask

  task automatic test_wrap;
    int cyc;
    logic [7:0] av [3] = '{8'd3, 8'd0, 8'd255};
    logic [7:0] bv [3] = '{8'd5, 8'd255, 8'd0};
    logic       bi [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] ey [3] = '{8'd254, 8'd0, 8'd255};
    logic       eb [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      start_op(av[i], bv[i], bi[i]);
      wait_done(cyc);
      n_cmp++;
      if (cyc != 8 || y !== ey[i] || borrow_out !== eb[i]) begin
        n_bad++;
        $display("FAIL wrap_%0d: got cyc=%0d y=%0d bo=%b, want cyc=8 y=%0d bo=%b", i, cyc, y, borrow_out, ey[i], eb[i]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    int pulses;
    start_op(8'd20, 8'd7, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a = 8'd1; b = 8'd2; borrow_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'hA5; b = 8'h3C;
    pulses = 0;
    cyc = 3;
    while (cyc < 14) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL ignored_start_pulses: got %0d done pulses, want 1", pulses);
    end
    n_cmp++;
    if (y !== 8'd13 || borrow_out !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignored_start_result: got y=%0d bo=%b busy=%b, want y=13 bo=0 busy=0", y, borrow_out, busy);
    end
  endtask

  task automatic test_reset_abort;
    int cyc;
    int pulses;
    start_op(8'd9, 8'd4, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (y !== 8'd5 || borrow_out !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_9m4: got y=%0d bo=%b, want y=5 bo=0", y, borrow_out);
    end
    start_op(8'd100, 8'd1, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, y, borrow_out} !== 11'd0) begin
      n_bad++;
      $display("FAIL abort_outputs: got busy=%b done=%b y=%0d bo=%b, want all 0", busy, done, y, borrow_out);
    end
    pulses = 0;
    repeat (4) begin @(posedge clk); #1; if (done === 1'b1) pulses++; end
    @(negedge clk) rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (done === 1'b1) pulses++; end
    n_cmp++;
    if (pulses != 0) begin
      n_bad++;
      $display("FAIL abort_no_done: got %0d done pulses, want 0", pulses);
    end
    start_op(8'd100, 8'd1, 1'b0);
    wait_done(cyc);
    n_cmp++;
    if (cyc != 8 || y !== 8'd99 || borrow_out !== 1'b0) begin
      n_bad++;
      $display("FAIL after_abort: got cyc=%0d y=%0d bo=%b, want cyc=8 y=99 bo=0", cyc, y, borrow_out);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    int e1;
    logic [7:0] gold;
    @(negedge clk);
    a = 8'd50; b = 8'd20; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'd20; b = 8'd50;
    wait_done(cyc);
    e1 = edge_cnt;
    gold = 8'(8'd50 - 8'd20 - 8'd0);
    n_cmp++;
    if (cyc != 8 || y !== 8'd30 || y !== gold || borrow_out !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_first: got cyc=%0d y=%0d bo=%b, want cyc=8 y=30 (gold %0d) bo=0", cyc, y, borrow_out, gold);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_reaccept: got busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    wait_done(cyc);
    gold = 8'(8'd20 - 8'd50 - 8'd0);
    n_cmp++;
    if (edge_cnt - e1 != 9) begin
      n_bad++;
      $display("FAIL b2b_spacing: got %0d edges between done pulses, want 9", edge_cnt - e1);
    end
    n_cmp++;
    if (y !== 8'd226 || y !== gold || borrow_out !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second: got y=%0d bo=%b, want y=226 (gold %0d) bo=1", y, borrow_out, gold);
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset;
    test_equal_latency;
    test_basic;
    test_wrap;
    test_start_while_busy;
    test_reset_abort;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
